// File: rtl/hps_reset_pkg.sv
// Shared types and constants for the HPS-to-fabric reset sequencer.
package hps_reset_pkg;

   typedef enum logic [1:0] {
      HOLD,
      LOCK,
      RELEASE,
      RUN
   } seq_state_t;

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_COLD = 2'b01;
   localparam logic [1:0] CAUSE_WARM = 2'b10;
   localparam logic [1:0] CAUSE_PLL  = 2'b11;

   localparam int COUNT_W = 8;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/reset_sync_bit.sv
// Single-bit flop-chain synchronizer whose chain is forced to RESET_VAL by
// the asynchronous active-low reset.
module reset_sync_bit #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_reg <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         chain_reg <= {chain_reg[SYNC_STAGES-2:0], d};
      end
   end

   assign q = chain_reg[SYNC_STAGES-1];

endmodule

// File: rtl/hps_fabric_reset_seq.sv
// Staged release of fabric domain resets driven by HPS cold/warm resets and
// PLL lock, with last-cause and event-count reporting.
module hps_fabric_reset_seq
   import hps_reset_pkg::*;
#(
   parameter int                     NUM_DOMAINS  = 4,
   parameter int                     STAGE_CYCLES = 16,
   parameter int                     LOCK_FILTER  = 8,
   parameter logic [NUM_DOMAINS-1:0] WARM_MASK    = 4'b1100,
   parameter int                     SYNC_STAGES  = 2
) (
   input  logic                   fpga_clk_50,
   input  logic                   hps_fpga_reset_n,
   input  logic                   h2f_cold_rst_n,
   input  logic                   h2f_warm_rst_n,
   input  logic                   pll_locked,
   output logic [NUM_DOMAINS-1:0] domain_rst_n,
   output logic                   seq_done,
   output logic [1:0]             last_cause,
   output logic [COUNT_W-1:0]     reset_count
);

   localparam int SW = $clog2(STAGE_CYCLES + 1);
   localparam int FW = $clog2(LOCK_FILTER + 1);
   localparam int IW = $clog2(NUM_DOMAINS + 1);

   localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_CYCLES - 1);
   localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DOMAINS - 1);

   logic cold_n_s, warm_n_s, locked_s;

   reset_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cold (
      .clk(fpga_clk_50), .rst_n(hps_fpga_reset_n), .d(h2f_cold_rst_n), .q(cold_n_s)
   );
   reset_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_warm (
      .clk(fpga_clk_50), .rst_n(hps_fpga_reset_n), .d(h2f_warm_rst_n), .q(warm_n_s)
   );
   reset_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_lock (
      .clk(fpga_clk_50), .rst_n(hps_fpga_reset_n), .d(pll_locked), .q(locked_s)
   );

   seq_state_t               state_reg, state_next;
   logic [NUM_DOMAINS-1:0]   mask_reg, mask_next;
   logic [NUM_DOMAINS-1:0]   rst_reg, rst_next;
   logic [SW-1:0]            stage_reg, stage_next;
   logic [FW-1:0]            filt_reg, filt_next;
   logic [IW-1:0]            idx_reg, idx_next;
   logic                     done_reg, done_next;
   logic [1:0]               cause_reg, cause_next;
   logic [COUNT_W-1:0]       count_reg, count_next;

   logic                     cold, warm, pll, trig;
   logic [NUM_DOMAINS-1:0]   trig_mask;
   logic [NUM_DOMAINS-1:0]   idx_sel;

   for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_idx_sel
      assign idx_sel[gi] = (idx_reg == IW'(gi));
   end

   // PLL loss only matters once the sequence has started releasing.
   assign cold      = !cold_n_s;
   assign warm      = !warm_n_s;
   assign pll       = !locked_s && (state_reg == RELEASE || state_reg == RUN);
   assign trig      = cold || warm || pll;
   assign trig_mask = (cold || pll) ? {NUM_DOMAINS{1'b1}} : WARM_MASK;

   always_comb begin
      state_next = state_reg;
      mask_next  = mask_reg;
      rst_next   = rst_reg;
      stage_next = stage_reg;
      filt_next  = filt_reg;
      idx_next   = idx_reg;
      cause_next = cause_reg;
      count_next = count_reg;

      if (trig) begin
         mask_next = mask_reg | trig_mask;
         rst_next  = rst_reg & ~(mask_reg | trig_mask);
      end

      case (state_reg)
         HOLD: begin
            rst_next = rst_reg & ~mask_next;
            if (!(cold || warm)) state_next = LOCK;
         end
         LOCK: begin
            if (cold || warm) begin
               state_next = HOLD;
            end else if (!locked_s) begin
               filt_next = '0;
            end else if (filt_reg == FILT_LAST) begin
               state_next = RELEASE;
            end else begin
               filt_next = filt_reg + 1'b1;
            end
         end
         RELEASE: begin
            if (trig) begin
               state_next = HOLD;
            end else if (stage_reg == STAGE_LAST) begin
               stage_next = '0;
               rst_next   = rst_reg | (idx_sel & mask_reg);
               if (idx_reg == IDX_LAST) begin
                  state_next = RUN;
                  mask_next  = '0;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end else begin
               stage_next = stage_reg + 1'b1;
            end
         end
         RUN: begin
            if (trig) state_next = HOLD;
         end
         default: state_next = HOLD;
      endcase

      // Counters never survive a state change, so each state starts fresh.
      if (state_next != state_reg) begin
         stage_next = '0;
         filt_next  = '0;
         idx_next   = '0;
      end

      if (state_reg != HOLD && state_next == HOLD) begin
         count_next = sat_inc(count_reg);
         cause_next = cold ? CAUSE_COLD : (pll ? CAUSE_PLL : CAUSE_WARM);
      end

      done_next = (state_next == RUN);
   end

   always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
      if (!hps_fpga_reset_n) begin
         state_reg <= HOLD;
         mask_reg  <= '1;
         rst_reg   <= '0;
         stage_reg <= '0;
         filt_reg  <= '0;
         idx_reg   <= '0;
         done_reg  <= 1'b0;
         cause_reg <= CAUSE_POR;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         mask_reg  <= mask_next;
         rst_reg   <= rst_next;
         stage_reg <= stage_next;
         filt_reg  <= filt_next;
         idx_reg   <= idx_next;
         done_reg  <= done_next;
         cause_reg <= cause_next;
         count_reg <= count_next;
      end
   end

   assign domain_rst_n = rst_reg;
   assign seq_done     = done_reg;
   assign last_cause   = cause_reg;
   assign reset_count  = count_reg;

endmodule

// File: tb/tb_hps_fabric_reset_seq.sv
// Scoreboard bench: stimulus queues expected output snapshots, a monitor
// compares them at every change of domain_rst_n (or on an explicit probe).
module tb_hps_fabric_reset_seq;

   logic       fpga_clk_50 = 1'b0;
   logic       hps_fpga_reset_n;
   logic       h2f_cold_rst_n;
   logic       h2f_warm_rst_n;
   logic       pll_locked;
   logic [3:0] domain_rst_n;
   logic       seq_done;
   logic [1:0] last_cause;
   logic [7:0] reset_count;

   hps_fabric_reset_seq dut (
      .fpga_clk_50      (fpga_clk_50),
      .hps_fpga_reset_n (hps_fpga_reset_n),
      .h2f_cold_rst_n   (h2f_cold_rst_n),
      .h2f_warm_rst_n   (h2f_warm_rst_n),
      .pll_locked       (pll_locked),
      .domain_rst_n     (domain_rst_n),
      .seq_done         (seq_done),
      .last_cause       (last_cause),
      .reset_count      (reset_count)
   );

   always #10 fpga_clk_50 = ~fpga_clk_50;

   typedef struct {
      logic [3:0] rst;
      logic       done;
      logic [1:0] cause;
      logic [7:0] count;
      int         gmin;
      int         gmax;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   ref_cyc = 0;
   bit   probe_req = 0;
   int   total = 0;
   int   passed = 0;

   always @(posedge fpga_clk_50) cyc <= cyc + 1;

   task automatic chk(input string name, input int ev, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s (event %0d): got %0h, required %0h", name, ev, act, exp);
   endtask

   task automatic chk_gap(input int ev, input int gap, input int gmin, input int gmax);
      total++;
      if (gap >= gmin && gap <= gmax) passed++;
      else $display("FAIL gap (event %0d): got %0d cycles, required %0d..%0d", ev, gap, gmin, gmax);
   endtask

   // Monitor
   initial begin
      logic [3:0] prev;
      int         gap;
      int         ev;
      exp_t       e;
      prev = 4'b0000;
      ev   = 0;
      forever begin
         @(negedge fpga_clk_50);
         if (probe_req || domain_rst_n !== prev) begin
            gap = cyc - ref_cyc;
            ev++;
            $display("event %0d @cyc %0d: domain_rst_n=%b seq_done=%b cause=%b count=%0d gap=%0d",
                     ev, cyc, domain_rst_n, seq_done, last_cause, reset_count, gap);
            if (q.size() == 0) begin
               total++;
               $display("FAIL unexpected_event (event %0d): got domain_rst_n=%b, required no change",
                        ev, domain_rst_n);
            end else begin
               e = q.pop_front();
               chk("domain_rst_n", ev, 32'(domain_rst_n), 32'(e.rst));
               chk("seq_done", ev, 32'(seq_done), 32'(e.done));
               chk("last_cause", ev, 32'(last_cause), 32'(e.cause));
               chk("reset_count", ev, 32'(reset_count), 32'(e.count));
               if (!probe_req) chk_gap(ev, gap, e.gmin, e.gmax);
            end
            if (!probe_req) ref_cyc = cyc;
            probe_req = 0;
            prev = domain_rst_n;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge fpga_clk_50);
      #2;
   endtask

   task automatic mark();
      ref_cyc = cyc;
   endtask

   task automatic push(input logic [3:0] rst, input logic done, input logic [1:0] cause,
                       input logic [7:0] count, input int gmin, input int gmax);
      exp_t e;
      e.rst = rst; e.done = done; e.cause = cause; e.count = count;
      e.gmin = gmin; e.gmax = gmax;
      q.push_back(e);
   endtask

   // Release staging from domain 'first' upward; later releases 16 cycles apart.
   task automatic push_rel(input logic [3:0] start, input int first, input int first_gap,
                           input logic [1:0] cause, input logic [7:0] count);
      logic [3:0] v;
      int         g;
      v = start;
      g = first_gap;
      for (int i = first; i < 4; i++) begin
         v[i] = 1'b1;
         push(v, (i == 3), cause, count, g, g);
         g = 16;
      end
   endtask

   task automatic drain(input int limit);
      int t;
      t = 0;
      while (q.size() != 0 && t < limit) begin
         tick(1);
         t++;
      end
      if (q.size() != 0) begin
         total++;
         $display("FAIL drain_timeout: got %0d outstanding snapshots, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic pulse_cold(input int len);
      mark();
      h2f_cold_rst_n = 1'b0;
      tick(len);
      h2f_cold_rst_n = 1'b1;
   endtask

   initial begin
      h2f_cold_rst_n   = 1'b1;
      h2f_warm_rst_n   = 1'b1;
      pll_locked       = 1'b1;
      hps_fpga_reset_n = 1'b1;
      #1 hps_fpga_reset_n = 1'b0;
      tick(3);

      // Reset state
      push(4'b0000, 1'b0, 2'b00, 8'd0, 0, 0);
      probe_req = 1;
      tick(2);

      // Power-on release
      push_rel(4'b0000, 0, 27, 2'b00, 8'd0);
      hps_fpga_reset_n = 1'b1;
      mark();
      drain(200);
      tick(4);

      // Cold pulse in RUN
      push(4'b0000, 1'b0, 2'b01, 8'd1, 2, 3);
      push_rel(4'b0000, 0, 29, 2'b01, 8'd1);
      pulse_cold(5);
      drain(200);
      tick(4);

      // Warm pulse in RUN: only domains 3:2 touched
      push(4'b0011, 1'b0, 2'b10, 8'd2, 2, 3);
      push_rel(4'b0011, 2, 61, 2'b10, 8'd2);
      mark();
      h2f_warm_rst_n = 1'b0;
      tick(5);
      h2f_warm_rst_n = 1'b1;
      drain(200);
      tick(4);

      // PLL loss after domain 1 released
      push(4'b0000, 1'b0, 2'b01, 8'd3, 2, 3);
      push(4'b0001, 1'b0, 2'b01, 8'd3, 29, 29);
      push(4'b0011, 1'b0, 2'b01, 8'd3, 16, 16);
      pulse_cold(5);
      drain(200);
      push(4'b0000, 1'b0, 2'b11, 8'd4, 2, 3);
      push_rel(4'b0000, 0, 33, 2'b01 | 2'b10, 8'd4);
      mark();
      pll_locked = 1'b0;
      tick(10);
      pll_locked = 1'b1;
      drain(200);
      tick(4);

      // Simultaneous cold and warm
      push(4'b0000, 1'b0, 2'b01, 8'd5, 2, 3);
      push_rel(4'b0000, 0, 29, 2'b01, 8'd5);
      mark();
      h2f_cold_rst_n = 1'b0;
      h2f_warm_rst_n = 1'b0;
      tick(5);
      h2f_cold_rst_n = 1'b1;
      h2f_warm_rst_n = 1'b1;
      drain(200);
      tick(4);

      // Lock glitch at filter count 7 restarts the filter
      push(4'b0000, 1'b0, 2'b01, 8'd6, 2, 3);
      push_rel(4'b0000, 0, 37, 2'b01, 8'd6);
      pulse_cold(5);
      tick(8);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      drain(200);
      tick(4);

      // 300 cold pulses: count saturates
      push(4'b0000, 1'b0, 2'b01, 8'd7, 2, 3);
      push_rel(4'b0000, 0, 27, 2'b01, 8'd255);
      mark();
      for (int p = 0; p < 300; p++) begin
         h2f_cold_rst_n = 1'b0;
         tick(3);
         h2f_cold_rst_n = 1'b1;
         if (p == 299) mark();
         else tick(4);
      end
      drain(200);
      tick(4);

      // Asynchronous block reset mid-RELEASE
      push(4'b0000, 1'b0, 2'b01, 8'd255, 2, 3);
      push(4'b0001, 1'b0, 2'b01, 8'd255, 29, 29);
      push(4'b0011, 1'b0, 2'b01, 8'd255, 16, 16);
      pulse_cold(5);
      drain(200);
      push(4'b0000, 1'b0, 2'b00, 8'd0, 0, 0);
      push_rel(4'b0000, 0, 27, 2'b00, 8'd0);
      tick(2);
      #3 hps_fpga_reset_n = 1'b0;
      mark();
      tick(3);
      hps_fpga_reset_n = 1'b1;
      mark();
      drain(200);
      tick(5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
